// File: rtl/parameter_def.sv
// rtl/parameter_def.sv - shared types and constants for the QAM frame packer
package parameter_def;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} frame_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_word_t;

  localparam int FIFO_WORD_W = $bits(fifo_word_t);

endpackage

// File: rtl/qam_frame_packer_fifo.sv
// rtl/qam_frame_packer_fifo.sv - synchronous first-word-fall-through FIFO
module qam_sync_fifo
  import parameter_def::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = FIFO_WORD_W
) (
  input  logic             axi_clk,
  input  logic             axi_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/qam_frame_packer.sv
// rtl/qam_frame_packer.sv - nibble-to-byte packer with sync lock and length-framed output
module qam_frame_packer
  import parameter_def::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        sym_valid,
  input  logic [3:0]  sym_data,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tlast,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic        overflow
);

  frame_state_t state, state_nxt;
  logic [7:0]   shreg;
  logic         ph, ph_nxt;
  logic [7:0]   rem, rem_nxt;
  logic         stage;
  logic [7:0]   cur_byte;
  fifo_word_t   stage_word;

  // One-deep staging register puts the FIFO write one edge after the completing nibble.
  logic         push_pend;
  fifo_word_t   push_word;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   fifo_push;
  logic                   drop;
  logic [FIFO_WORD_W-1:0] fifo_dout;
  fifo_word_t             head;

  logic        locked_q;
  logic [15:0] frame_cnt_q;
  logic        overflow_q;

  assign cur_byte   = {shreg[3:0], sym_data};
  assign stage_word = '{last: (rem == 8'd1), data: cur_byte};

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph;
    rem_nxt   = rem;
    stage     = 1'b0;
    case (state)
      HUNT: begin
        if (sym_valid && (cur_byte == SYNC_BYTE)) begin
          state_nxt = LEN;
          ph_nxt    = 1'b0;
        end
      end
      LEN: begin
        if (sym_valid) begin
          ph_nxt = ~ph;
          if (ph) begin
            rem_nxt   = cur_byte;
            state_nxt = (cur_byte == 8'd0) ? HUNT : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (sym_valid) begin
          ph_nxt = ~ph;
          if (ph) begin
            stage   = 1'b1;
            rem_nxt = rem - 8'd1;
            if (rem == 8'd1) state_nxt = HUNT;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign fifo_pop  = !fifo_empty && m_tready;
  assign fifo_push = push_pend && (!fifo_full || fifo_pop);
  assign drop      = push_pend && !fifo_push;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state       <= HUNT;
      shreg       <= 8'd0;
      ph          <= 1'b0;
      rem         <= 8'd0;
      push_pend   <= 1'b0;
      push_word   <= '0;
      locked_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
      overflow_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      rem       <= rem_nxt;
      push_pend <= stage;
      locked_q  <= (state_nxt != HUNT);
      if (sym_valid) shreg <= cur_byte;
      if (stage) push_word <= stage_word;
      if (fifo_push && push_word.last) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  qam_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WORD_W)
  ) u_fifo (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .push    (fifo_push),
    .din     (push_word),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty)
  );

  assign head      = fifo_dout;
  assign m_tvalid  = !fifo_empty;
  assign m_tdata   = head.data;
  assign m_tlast   = head.last;
  assign locked    = locked_q;
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_qam_frame_packer.sv
// tb/tb_qam_frame_packer.sv - randomized self-checking bench for qam_frame_packer
module tb_qam_frame_packer;

  localparam int DEPTH = 8;
  localparam int NOCAP = 1 << 20;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic        sym_valid = 1'b0;
  logic [3:0]  sym_data = 4'd0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic        locked;
  logic [15:0] frame_cnt;
  logic        overflow;

  always #5 axi_clk = ~axi_clk;

  qam_frame_packer #(
    .SYNC_BYTE  (8'hA5),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .axi_clk   (axi_clk),
    .axi_rst   (axi_rst),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .locked    (locked),
    .frame_cnt (frame_cnt),
    .overflow  (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: parses the nibble stream as sync / length / payload bytes.
  logic [3:0] stim [$];
  logic [8:0] exp_q [$];
  int         exp_frames = 0;
  logic       exp_ovf = 1'b0;
  logic [3:0] m_prev = 4'd0;
  int         tready_mode = 1;

  task automatic model_stream(input int cap);
    int i;
    int len;
    int pushed;
    logic [7:0] b;
    i = 0;
    pushed = 0;
    while (i < stim.size()) begin
      b = {m_prev, stim[i]};
      m_prev = stim[i];
      i++;
      if (b == 8'hA5 && i + 1 < stim.size()) begin
        len = int'({stim[i], stim[i+1]});
        m_prev = stim[i+1];
        i += 2;
        for (int k = 0; k < len; k++) begin
          if (i + 1 >= stim.size()) break;
          b = {stim[i], stim[i+1]};
          m_prev = stim[i+1];
          i += 2;
          if (pushed < cap) begin
            exp_q.push_back({(k == len - 1), b});
            pushed++;
            if (k == len - 1) exp_frames++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic send(input logic [3:0] n, input int gap);
    sym_valid = 1'b1;
    sym_data  = n;
    @(posedge axi_clk); #1;
    sym_valid = 1'b0;
    repeat (gap) begin
      @(posedge axi_clk); #1;
    end
  endtask

  task automatic run_stream(input int gap, input int cap);
    model_stream(cap);
    foreach (stim[i]) send(stim[i], gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge axi_clk); #1;
      t++;
    end
    check_eq("drain_timeout", exp_q.size(), 0);
    repeat (3) begin
      @(posedge axi_clk); #1;
    end
    check_eq("idle_tvalid", m_tvalid, 0);
    check_eq("frame_cnt", frame_cnt, exp_frames[15:0]);
    check_eq("overflow", overflow, exp_ovf);
    check_eq("locked_idle", locked, 0);
  endtask

  task automatic build_random(input int len);
    logic [7:0] b;
    stim.delete();
    repeat ($urandom_range(0, 3)) stim.push_back(4'($urandom_range(0, 4)));
    stim.push_back(4'hA);
    stim.push_back(4'h5);
    b = 8'(len);
    stim.push_back(b[7:4]);
    stim.push_back(b[3:0]);
    repeat (len) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back(b[7:4]);
      stim.push_back(b[3:0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge axi_clk); #1;
      case (tready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  always @(negedge axi_clk) begin
    logic [8:0] e;
    if (axi_rst) begin
      hold_v = 1'b0;
    end else begin
      if (m_tvalid && hold_v) begin
        check_eq("stall_data", m_tdata, hold_d);
        check_eq("stall_last", m_tlast, hold_l);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("data", m_tdata, e[7:0]);
          check_eq("last", m_tlast, e[8]);
        end
        hold_v = 1'b0;
      end else if (m_tvalid) begin
        hold_v = 1'b1;
        hold_d = m_tdata;
        hold_l = m_tlast;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge axi_clk);
    #1;
    axi_rst = 1'b0;
    check_eq("rst_tvalid", m_tvalid, 0);
    check_eq("rst_tdata", m_tdata, 0);
    check_eq("rst_tlast", m_tlast, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_overflow", overflow, 0);

    // Aligned frame, locked sampled once the length byte is in.
    stim = '{4'hA, 4'h5, 4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    model_stream(NOCAP);
    check_eq("aligned_model_bytes", exp_q.size(), 3);
    foreach (stim[i]) begin
      send(stim[i], 1);
      if (i == 3) check_eq("locked_mid", locked, 1);
    end
    drain();

    // Sync at odd nibble phase.
    stim = '{4'hF, 4'hA, 4'h5, 4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    run_stream(1, NOCAP);
    drain();

    // Zero length followed by a one-byte frame, at full symbol rate.
    stim = '{4'hA, 4'h5, 4'h0, 4'h0, 4'hA, 4'h5, 4'h0, 4'h1, 4'h7, 4'h7};
    run_stream(0, NOCAP);
    drain();

    for (int r = 0; r < 6; r++) begin
      tready_mode = 1 + (r % 2);
      build_random($urandom_range(1, 6));
      run_stream($urandom_range(0, 2), NOCAP);
      drain();
    end

    // Random backpressure during a 5-byte frame.
    tready_mode = 2;
    build_random(5);
    run_stream($urandom_range(0, 1), NOCAP);
    drain();

    // Overflow: 10 bytes into an 8-deep FIFO with no reader.
    tready_mode = 0;
    stim = '{4'hA, 4'h5, 4'h0, 4'hA};
    for (int k = 0; k < 10; k++) begin
      stim.push_back(4'h0);
      stim.push_back(4'(k));
    end
    run_stream(1, DEPTH);
    repeat (4) begin
      @(posedge axi_clk); #1;
    end
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_frame_cnt", frame_cnt, exp_frames[15:0]);
    check_eq("ovf_tvalid", m_tvalid, 1);
    tready_mode = 1;
    drain();

    // Reset after 2 of 4 payload bytes.
    stim = '{4'hA, 4'h5, 4'h0, 4'h4, 4'h1, 4'h1, 4'h2, 4'h2};
    run_stream(1, NOCAP);
    repeat (6) begin
      @(posedge axi_clk); #1;
    end
    check_eq("pre_rst_delivered", exp_q.size(), 0);
    axi_rst = 1'b1;
    @(posedge axi_clk); #1;
    axi_rst = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_ovf = 1'b0;
    m_prev = 4'd0;
    check_eq("mid_rst_tvalid", m_tvalid, 0);
    check_eq("mid_rst_tdata", m_tdata, 0);
    check_eq("mid_rst_tlast", m_tlast, 0);
    check_eq("mid_rst_locked", locked, 0);
    check_eq("mid_rst_frame_cnt", frame_cnt, 0);
    check_eq("mid_rst_overflow", overflow, 0);
    build_random(3);
    run_stream(1, NOCAP);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
